// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl_if
// Description : Bundles the core-side request signals and the RAM-side
//               handshake signals of mem_access_ctrl.
//               slave  = the controller, master = core plus RAM.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 10
);
  // Core side
  logic                  MEM_ACCESS_CTRL_Req;
  logic                  MEM_ACCESS_CTRL_We;
  logic [2:0]            MEM_ACCESS_CTRL_Funct3;
  logic [31:0]           MEM_ACCESS_CTRL_Byte_Address;
  logic [31:0]           MEM_ACCESS_CTRL_Write_Data;
  logic [31:0]           MEM_ACCESS_CTRL_Read_Data;
  logic                  MEM_ACCESS_CTRL_Done;
  logic                  MEM_ACCESS_CTRL_Busy;
  logic                  MEM_ACCESS_CTRL_Misalign;
  // RAM side
  logic                  Ram_Read_Ready;
  logic                  Ram_Write_Valid;
  logic [ADDR_WIDTH-1:0] Ram_Address;
  logic [31:0]           Ram_Wdata;
  logic                  Ram_Read_Valid;
  logic                  Ram_Write_Ready;
  logic [31:0]           Ram_Rdata;

  modport slave (
    input  MEM_ACCESS_CTRL_Req, MEM_ACCESS_CTRL_We, MEM_ACCESS_CTRL_Funct3,
    input  MEM_ACCESS_CTRL_Byte_Address, MEM_ACCESS_CTRL_Write_Data,
    output MEM_ACCESS_CTRL_Read_Data, MEM_ACCESS_CTRL_Done,
    output MEM_ACCESS_CTRL_Busy, MEM_ACCESS_CTRL_Misalign,
    output Ram_Read_Ready, Ram_Write_Valid, Ram_Address, Ram_Wdata,
    input  Ram_Read_Valid, Ram_Write_Ready, Ram_Rdata
  );

  modport master (
    output MEM_ACCESS_CTRL_Req, MEM_ACCESS_CTRL_We, MEM_ACCESS_CTRL_Funct3,
    output MEM_ACCESS_CTRL_Byte_Address, MEM_ACCESS_CTRL_Write_Data,
    input  MEM_ACCESS_CTRL_Read_Data, MEM_ACCESS_CTRL_Done,
    input  MEM_ACCESS_CTRL_Busy, MEM_ACCESS_CTRL_Misalign,
    input  Ram_Read_Ready, Ram_Write_Valid, Ram_Address, Ram_Wdata,
    output Ram_Read_Valid, Ram_Write_Ready, Ram_Rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Load/store unit between a core and a word-wide RAM with a
//               registered read port. Sub-word stores use read-modify-write;
//               loads extract and sign/zero-extend bytes and halfwords.
//               Optional feature macro: MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
//               (misaligned H/HU/W accesses complete without RAM access and
//               raise Misalign).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input wire               MEM_ACCESS_CTRL_Clk,
  input wire               MEM_ACCESS_CTRL_Reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_REQ = 3'd1,
    RD_CAP = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  state_t                r_state;
  state_t                w_next;
  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [1:0]            r_offset;
  logic [15:0]           r_store_data;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic [31:0]           r_ram_wdata;
  logic [31:0]           r_read_data;
  logic                  r_misalign;

  logic                  w_f3_valid;
  logic                  w_is_word;
  logic                  w_is_half;
  logic                  w_misalign;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_result;
  logic [31:0]           w_merged;

  // Upper address bits beyond the RAM are intentionally ignored.
  wire w_unused = &{1'b0, bus.MEM_ACCESS_CTRL_Byte_Address[31:ADDR_WIDTH+2]};

  // Decode the incoming request's access size.
  always_comb begin
    w_f3_valid = (bus.MEM_ACCESS_CTRL_Funct3 == c_F3_B)  ||
                 (bus.MEM_ACCESS_CTRL_Funct3 == c_F3_H)  ||
                 (bus.MEM_ACCESS_CTRL_Funct3 == c_F3_W)  ||
                 (bus.MEM_ACCESS_CTRL_Funct3 == c_F3_BU) ||
                 (bus.MEM_ACCESS_CTRL_Funct3 == c_F3_HU);
    w_is_word  = (bus.MEM_ACCESS_CTRL_Funct3 == c_F3_W);
    w_is_half  = w_f3_valid && (bus.MEM_ACCESS_CTRL_Funct3[1:0] == 2'b01);
`ifdef MEM_ACCESS_CTRL_MISALIGN_TRAP_EN
    w_misalign = (w_is_half && bus.MEM_ACCESS_CTRL_Byte_Address[0]) ||
                 (w_is_word && (bus.MEM_ACCESS_CTRL_Byte_Address[1:0] != 2'b00));
`else
    // Without trapping, misaligned halfwords/words simply drop the low bits.
    w_misalign = 1'b0;
`endif
  end

  // Select and extend the loaded lane straight from the RAM data port.
  always_comb begin
    w_load_result = '0;
    case (r_offset)
      2'd0:    w_byte = bus.Ram_Rdata[7:0];
      2'd1:    w_byte = bus.Ram_Rdata[15:8];
      2'd2:    w_byte = bus.Ram_Rdata[23:16];
      default: w_byte = bus.Ram_Rdata[31:24];
    endcase
    w_half = r_offset[1] ? bus.Ram_Rdata[31:16] : bus.Ram_Rdata[15:0];
    case (r_funct3)
      c_F3_B:  w_load_result = {{24{w_byte[7]}}, w_byte};
      c_F3_BU: w_load_result = {24'd0, w_byte};
      c_F3_H:  w_load_result = {{16{w_half[15]}}, w_half};
      c_F3_HU: w_load_result = {16'd0, w_half};
      c_F3_W:  w_load_result = bus.Ram_Rdata;
      default: w_load_result = '0;
    endcase
  end

  // Merge the store lane into the word just read back from RAM.
  always_comb begin
    w_merged = bus.Ram_Rdata;
    if (r_funct3[1:0] == 2'b00) begin
      case (r_offset)
        2'd0:    w_merged[7:0]   = r_store_data[7:0];
        2'd1:    w_merged[15:8]  = r_store_data[7:0];
        2'd2:    w_merged[23:16] = r_store_data[7:0];
        default: w_merged[31:24] = r_store_data[7:0];
      endcase
    end else if (r_offset[1]) begin
      w_merged[31:16] = r_store_data;
    end else begin
      w_merged[15:0]  = r_store_data;
    end
  end

  // Next-state decision for the access sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.MEM_ACCESS_CTRL_Req) begin
          if (!w_f3_valid || w_misalign)
            w_next = DONE;
          else if (bus.MEM_ACCESS_CTRL_We && w_is_word)
            w_next = WR;
          else
            w_next = RD_REQ;
        end
      end
      RD_REQ:  if (bus.Ram_Read_Valid) w_next = RD_CAP;
      RD_CAP:  w_next = r_we ? WR : DONE;
      WR:      if (bus.Ram_Write_Ready) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register plus request capture, RAM data capture and result update.
  always_ff @(posedge MEM_ACCESS_CTRL_Clk) begin
    if (MEM_ACCESS_CTRL_Reset) begin
      r_state       <= IDLE;
      r_we          <= 1'b0;
      r_funct3      <= '0;
      r_offset      <= '0;
      r_store_data  <= '0;
      r_ram_address <= '0;
      r_ram_wdata   <= '0;
      r_read_data   <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (bus.MEM_ACCESS_CTRL_Req) begin
            r_we          <= bus.MEM_ACCESS_CTRL_We;
            r_funct3      <= bus.MEM_ACCESS_CTRL_Funct3;
            r_offset      <= bus.MEM_ACCESS_CTRL_Byte_Address[1:0];
            r_store_data  <= bus.MEM_ACCESS_CTRL_Write_Data[15:0];
            r_ram_address <= bus.MEM_ACCESS_CTRL_Byte_Address[ADDR_WIDTH+1:2];
            r_misalign    <= w_misalign;
            if (bus.MEM_ACCESS_CTRL_We && w_is_word && !w_misalign)
              r_ram_wdata <= bus.MEM_ACCESS_CTRL_Write_Data;
            // Invalid-size load clears the result, visible during DONE.
            if (!bus.MEM_ACCESS_CTRL_We && !w_f3_valid)
              r_read_data <= '0;
          end
        end
        RD_CAP: begin
          // Result is registered on entry to DONE so it is valid with Done.
          if (r_we)
            r_ram_wdata <= w_merged;
          else
            r_read_data <= w_load_result;
        end
        DONE:    r_misalign <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.MEM_ACCESS_CTRL_Read_Data = r_read_data;
  assign bus.MEM_ACCESS_CTRL_Done      = (r_state == DONE);
  assign bus.MEM_ACCESS_CTRL_Busy      = (r_state != IDLE);
  assign bus.MEM_ACCESS_CTRL_Misalign  = r_misalign && (r_state == DONE);
  assign bus.Ram_Read_Ready            = (r_state == RD_REQ) || (r_state == RD_CAP);
  assign bus.Ram_Write_Valid           = (r_state == WR);
  assign bus.Ram_Address               = r_ram_address;
  assign bus.Ram_Wdata                 = r_ram_wdata;

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, the RAM word-address width.
REQ-002 SHALL have port MEM_ACCESS_CTRL_Clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port MEM_ACCESS_CTRL_Reset, input, 1, the reset; synchronous, active-high.
REQ-004 SHALL have port MEM_ACCESS_CTRL_Req, input, 1, a core access request, sampled only in IDLE.
REQ-005 SHALL have port MEM_ACCESS_CTRL_We, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port MEM_ACCESS_CTRL_Funct3, input, 3, the access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port MEM_ACCESS_CTRL_Byte_Address, input, 32, the byte address.
REQ-008 SHALL have port MEM_ACCESS_CTRL_Write_Data, input, 32, the store data, right-aligned.
REQ-009 SHALL have port MEM_ACCESS_CTRL_Read_Data, output, 32, the extended load result.
REQ-010 SHALL have port MEM_ACCESS_CTRL_Done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port MEM_ACCESS_CTRL_Busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port MEM_ACCESS_CTRL_Misalign, output, 1, the misaligned-access flag, valid with Done.
REQ-013 SHALL have RAM-side ports: Ram_Read_Ready out 1; Ram_Write_Valid out 1; Ram_Address out ADDR_WIDTH; Ram_Wdata out 32; Ram_Read_Valid in 1; Ram_Write_Ready in 1; Ram_Rdata in 32 (RAM Data_Out, registered, 1-cycle latency, zero when not read).

Function
REQ-014 SHALL implement FSM states IDLE, RD_REQ, RD_CAP, WR, DONE.
REQ-015 Transitions SHALL be:
- IDLE, Req=1: load -> RD_REQ; word store -> WR; byte/half store -> RD_REQ (read-modify-write); invalid Funct3 -> DONE.
- RD_REQ: remain until Ram_Read_Valid=1, then -> RD_CAP.
- RD_CAP: load -> DONE; RMW store -> WR.
- WR: remain until Ram_Write_Ready=1, then -> DONE.
- DONE -> IDLE.
REQ-016 Ram_Address SHALL be Byte_Address[ADDR_WIDTH+1:2], registered at request acceptance and held until IDLE.
REQ-017 Ram_Read_Ready SHALL be high in RD_REQ and RD_CAP only; Ram_Rdata SHALL be captured in RD_CAP.
REQ-018 Ram_Write_Valid SHALL be high in WR only; the write commits at the edge where Ram_Write_Ready=1.
REQ-019 RMW merge SHALL work as follows: SB replaces byte Byte_Address[1:0] of the captured word with Write_Data[7:0]; SH replaces halfword Byte_Address[1] with Write_Data[15:0]; SW uses Write_Data unmodified.
REQ-020 Loads SHALL select the byte or halfword by the same address bits: B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-021 Read_Data SHALL update only in DONE of a load and SHALL hold otherwise; an invalid-Funct3 load SHALL set it to 0.
REQ-022 Done SHALL be high exactly in DONE.
REQ-023 Latency from the accepting edge SHALL be: load and SW with Ready already high -> Done 3 and 2 cycles later respectively; SB/SH -> 4 cycles later.
REQ-024 Req SHALL be ignored while Busy; back-to-back requests SHALL be accepted in the IDLE cycle following DONE.
REQ-025 Stores SHALL never drive Read_Data; loads SHALL never assert Ram_Write_Valid.

Reset
REQ-026 Reset SHALL force IDLE and set Read_Data=0, Done=0, Busy=0, Misalign=0, Ram_Read_Ready=0, Ram_Write_Valid=0, Ram_Address=0, Ram_Wdata=0.
REQ-027 Reset SHALL take priority over Req.
REQ-028 Reset mid-operation SHALL abort with no Done pulse; the RAM has no reset, so a write in WR at the reset edge may commit, and no strobe SHALL be high after that edge.

Configuration
REQ-029 With MEM_ACCESS_CTRL_MISALIGN_TRAP_EN defined:
- H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL go IDLE -> DONE with no RAM access.
- Misalign SHALL be 1 during that DONE.
- Read_Data SHALL be unchanged.
REQ-030 Without MEM_ACCESS_CTRL_MISALIGN_TRAP_EN:
- Misalign SHALL be tied 0.
- Halfword accesses SHALL ignore addr[0]; word accesses SHALL ignore addr[1:0].

Verification
REQ-031 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> Ram_Address=4, Done 2 and 3 cycles after acceptance, Read_Data=0xDEADBEEF.
REQ-032 SB 0x11 data 0x55 over word 0xDEADBEEF -> RAM word 0xDEAD55EF, Done 4 cycles after; then LB 0x11 -> 0x00000055, LBU 0x13 -> 0x000000DE, LB 0x13 -> 0xFFFFFFDE.
REQ-033 Hold Ram_Write_Ready low 3 cycles during SW -> WR held, Ram_Write_Valid stable, Done one cycle after Ready rises.
REQ-034 Reset pulsed in RD_REQ of a load -> IDLE next cycle, no Done, Read_Data=0, strobes low.
REQ-035 LH 0x13 with macro defined -> Done 1 cycle after, Misalign=1, no Ram_Read_Ready; without macro -> reads halfword 1 of word 4, Misalign=0.
